// File: rtl/masked_and_dom_pipe_if.sv
// Share-domain handshake bundle for the DOM masked AND gadget.
// master = upstream/downstream driver side, slave = the gadget itself.
interface masked_and_dom_pipe_if #(
  parameter int unsigned D = 2
);
  localparam int unsigned RAND_W = D * (D - 1) / 2;

  logic              in_valid;
  logic              in_ready;
  logic [0:D-1]      ina;
  logic [0:D-1]      inb;
  logic [0:RAND_W-1] rin;
  logic [0:D-1]      out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid, ina, inb, rin, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_valid, ina, inb, rin, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/masked_and_dom_pipe.sv
// D-share DOM-indep masked AND, 2-cycle pipeline with valid/ready backpressure.
// Every cross term is registered on its own before any cross-domain XOR.
(* keep_hierarchy = "yes" *)
module masked_and_dom_pipe #(
  parameter int unsigned D = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  and_enable,
  masked_and_dom_pipe_if.slave  bus,
  output logic                  busy
);
  localparam int unsigned RAND_W = D * (D - 1) / 2;
  localparam int unsigned NCROSS = D * (D - 1);

  // Randomness bit shared by the pair (i,j), i<j.
  function automatic int unsigned rand_idx(input int unsigned i, input int unsigned j);
    return i * D - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Flat slot of cross term z_ij, i!=j (diagonal skipped).
  function automatic int unsigned cross_idx(input int unsigned i, input int unsigned j);
    return i * (D - 1) + ((j < i) ? j : (j - 1));
  endfunction

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, accept;

  (* dont_touch = "true" *) logic [0:D-1]      p_q;
  (* dont_touch = "true" *) logic [0:NCROSS-1] z_q;
  (* dont_touch = "true" *) logic [0:D-1]      out_q;

  logic [0:D-1]      p_d;
  logic [0:NCROSS-1] z_d;
  logic [0:D-1]      out_d;

  assign s2_adv       = bus.out_ready | ~s2_valid;
  assign s1_adv       = s2_adv | ~s1_valid;
  assign bus.in_ready = rst_n & and_enable & s1_adv;
  assign accept       = bus.in_valid & bus.in_ready;
  assign busy         = s1_valid | s2_valid;
  assign bus.out      = out_q;
  assign bus.out_valid = s2_valid;

  always_comb begin
    p_d = '0;
    z_d = '0;
    for (int unsigned i = 0; i < D; i++) begin
      p_d[i] = bus.ina[i] & bus.inb[i];
      for (int unsigned j = 0; j < D; j++) begin
        if (j != i) begin
          z_d[cross_idx(i, j)] = (bus.ina[i] & bus.inb[j]) ^
                                 bus.rin[rand_idx((i < j) ? i : j, (i < j) ? j : i)];
        end
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < D; i++) begin
      out_d[i] = p_q[i];
      for (int unsigned j = 0; j < D; j++) begin
        if (j != i) begin
          out_d[i] = out_d[i] ^ z_q[cross_idx(i, j)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      p_q      <= '0;
      z_q      <= '0;
      out_q    <= '0;
    end else if (!and_enable) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      p_q      <= '0;
      z_q      <= '0;
      out_q    <= '0;
    end else begin
      // Share registers load only on real transfers so idle inputs never leak in.
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          p_q <= p_d;
          z_q <= z_d;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_q <= out_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_masked_and_dom_pipe.sv
// Directed + scoreboard bench for masked_and_dom_pipe, D=2 and D=3 instances.
module tb_masked_and_dom_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic and_enable;
  logic busy2, busy3;

  always #5 clk = ~clk;

  masked_and_dom_pipe_if #(.D(2)) if2 ();
  masked_and_dom_pipe_if #(.D(3)) if3 ();

  masked_and_dom_pipe #(.D(2)) u2 (
    .clk(clk), .rst_n(rst_n), .and_enable(and_enable), .bus(if2.slave), .busy(busy2)
  );
  masked_and_dom_pipe #(.D(3)) u3 (
    .clk(clk), .rst_n(rst_n), .and_enable(and_enable), .bus(if3.slave), .busy(busy3)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned pops3 = 0;
  logic acc2, acc3;
  logic [0:1] q2[$];
  logic [0:2] q3[$];
  logic       pr2[$];
  logic       pr3[$];

  // Reference shares: out_i = a_i b_i ^ XOR_{j!=i} (a_i b_j ^ r_{min,max}).
  function automatic logic [0:7] model(input int unsigned d, input logic [0:7] a,
                                       input logic [0:7] b, input logic [0:7] r);
    logic [0:7] o;
    int unsigned lo, hi, k;
    o = '0;
    for (int unsigned i = 0; i < d; i++) begin
      o[i] = a[i] & b[i];
      for (int unsigned j = 0; j < d; j++) begin
        if (j != i) begin
          lo = (i < j) ? i : j;
          hi = (i < j) ? j : i;
          k  = lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
          o[i] = o[i] ^ (a[i] & b[j]) ^ r[k];
        end
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [0:7] a8, b8, r8, o8;
    logic [0:1] e2;
    logic [0:2] e3;
    acc2 = 1'b0;
    acc3 = 1'b0;
    if (!rst_n || !and_enable) begin
      q2.delete(); pr2.delete();
      q3.delete(); pr3.delete();
    end else begin
      if (if2.out_valid && if2.out_ready) begin
        n_cmp++;
        assert (q2.size() != 0) else begin
          n_err++;
          $error("FAIL d2_unexpected_out: observed out=%b expected no output", if2.out);
        end
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          check("d2_out_shares", 32'(if2.out), 32'(e2));
          check("d2_xor_eq_and", 32'(^if2.out), 32'(pr2.pop_front()));
        end
      end
      if (if3.out_valid && if3.out_ready) begin
        n_cmp++;
        assert (q3.size() != 0) else begin
          n_err++;
          $error("FAIL d3_unexpected_out: observed out=%b expected no output", if3.out);
        end
        if (q3.size() != 0) begin
          e3 = q3.pop_front();
          check("d3_out_shares", 32'(if3.out), 32'(e3));
          check("d3_xor_eq_and", 32'(^if3.out), 32'(pr3.pop_front()));
          pops3++;
        end
      end
      if (if2.in_valid && if2.in_ready) begin
        a8 = '0; b8 = '0; r8 = '0;
        for (int unsigned i = 0; i < 2; i++) begin a8[i] = if2.ina[i]; b8[i] = if2.inb[i]; end
        r8[0] = if2.rin[0];
        o8 = model(2, a8, b8, r8);
        q2.push_back(o8[0:1]);
        pr2.push_back((^if2.ina) & (^if2.inb));
        acc2 = 1'b1;
      end
      if (if3.in_valid && if3.in_ready) begin
        a8 = '0; b8 = '0; r8 = '0;
        for (int unsigned i = 0; i < 3; i++) begin
          a8[i] = if3.ina[i]; b8[i] = if3.inb[i]; r8[i] = if3.rin[i];
        end
        o8 = model(3, a8, b8, r8);
        q3.push_back(o8[0:2]);
        pr3.push_back((^if3.ina) & (^if3.inb));
        acc3 = 1'b1;
      end
    end
  endtask

  // Inputs change #1 after a rising edge; the scoreboard samples at the falling edge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:1] snap2;
    int unsigned sent, pops_start, c;
    rst_n = 1'b0;
    and_enable = 1'b1;
    if2.in_valid = 1'b0; if2.ina = '0; if2.inb = '0; if2.rin = '0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.ina = '0; if3.inb = '0; if3.rin = '0; if3.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready2", 32'(if2.in_ready), 32'd0);
    check("rst_in_ready3", 32'(if3.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_out2", 32'(if2.out), 32'd0);
    check("post_rst_valid2", 32'(if2.out_valid), 32'd0);
    check("post_rst_busy2", 32'(busy2), 32'd0);
    check("post_rst_out3", 32'(if3.out), 32'd0);
    check("post_rst_busy3", 32'(busy3), 32'd0);
    check("post_rst_in_ready2", 32'(if2.in_ready), 32'd1);

    // D=2 directed op with latency check
    if2.ina = 2'b10; if2.inb = 2'b01; if2.rin = 1'b1; if2.in_valid = 1'b1;
    step();
    if2.in_valid = 1'b0;
    check("d2_lat_valid_n1", 32'(if2.out_valid), 32'd0);
    check("d2_lat_busy_n1", 32'(busy2), 32'd1);
    step();
    check("d2_dir_out", 32'(if2.out), 32'(2'b01));
    check("d2_dir_valid", 32'(if2.out_valid), 32'd1);
    check("d2_dir_xor", 32'(^if2.out), 32'd1);
    step();

    // D=3 directed ops, differing randomness
    if3.ina = 3'b100; if3.inb = 3'b111; if3.rin = 3'b100; if3.in_valid = 1'b1;
    step();
    if3.rin = 3'b000;
    step();
    if3.in_valid = 1'b0;
    check("d3_dir_out_r100", 32'(if3.out), 32'(3'b010));
    check("d3_dir_valid", 32'(if3.out_valid), 32'd1);
    step();
    check("d3_dir_out_r000", 32'(if3.out), 32'(3'b100));
    step(); step();

    // D=3 streaming, 16 back-to-back ops
    pops_start = pops3;
    for (int n = 0; n < 16; n++) begin
      if3.ina = 3'($urandom); if3.inb = 3'($urandom); if3.rin = 3'($urandom);
      if3.in_valid = 1'b1;
      check("d3_stream_in_ready", 32'(if3.in_ready), 32'd1);
      step();
    end
    if3.in_valid = 1'b0;
    repeat (3) step();
    check("d3_stream_count", pops3 - pops_start, 32'd16);

    // D=2 backpressure
    if2.out_ready = 1'b0;
    if2.ina = 2'($urandom); if2.inb = 2'($urandom); if2.rin = 1'($urandom);
    if2.in_valid = 1'b1;
    sent = 0;
    repeat (2) begin
      step();
      if (acc2) begin
        sent++;
        if2.ina = 2'($urandom); if2.inb = 2'($urandom); if2.rin = 1'($urandom);
      end
    end
    check("d2_bp_fill", sent, 32'd2);
    check("d2_bp_in_ready_full", 32'(if2.in_ready), 32'd0);
    snap2 = if2.out;
    repeat (5) begin
      step();
      check("d2_bp_out_stable", 32'(if2.out), 32'(snap2));
      check("d2_bp_valid_held", 32'(if2.out_valid), 32'd1);
      check("d2_bp_in_ready", 32'(if2.in_ready), 32'd0);
    end
    if2.out_ready = 1'b1;
    for (int n = 0; n < 20 && sent < 6; n++) begin
      step();
      if (acc2) begin
        sent++;
        if2.ina = 2'($urandom); if2.inb = 2'($urandom); if2.rin = 1'($urandom);
      end
    end
    check("d2_bp_resume", sent, 32'd6);
    if2.in_valid = 1'b0;
    repeat (3) step();

    // Flush with two ops in flight
    for (int n = 0; n < 2; n++) begin
      if3.ina = 3'($urandom); if3.inb = 3'($urandom); if3.rin = 3'($urandom);
      if3.in_valid = 1'b1;
      step();
    end
    if3.in_valid = 1'b0;
    and_enable = 1'b0;
    step();
    and_enable = 1'b1;
    check("flush_out", 32'(if3.out), 32'd0);
    check("flush_valid", 32'(if3.out_valid), 32'd0);
    check("flush_busy", 32'(busy3), 32'd0);
    repeat (2) step();

    // Asynchronous reset between edges
    if2.ina = 2'($urandom); if2.inb = 2'($urandom); if2.rin = 1'($urandom); if2.in_valid = 1'b1;
    if3.ina = 3'($urandom); if3.inb = 3'($urandom); if3.rin = 3'($urandom); if3.in_valid = 1'b1;
    step(); step();
    if2.in_valid = 1'b0; if3.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out2", 32'(if2.out), 32'd0);
    check("arst_valid2", 32'(if2.out_valid), 32'd0);
    check("arst_busy2", 32'(busy2), 32'd0);
    check("arst_out3", 32'(if3.out), 32'd0);
    check("arst_busy3", 32'(busy3), 32'd0);
    check("arst_in_ready2", 32'(if2.in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_no_partial", 32'(if3.out_valid), 32'd0);

    // Exhaustive D=2: every ina/inb/rin combination
    for (c = 0; c < 32; c++) begin
      if2.ina = c[4:3]; if2.inb = c[2:1]; if2.rin = c[0:0];
      if2.in_valid = 1'b1;
      check("d2_exh_in_ready", 32'(if2.in_ready), 32'd1);
      step();
    end
    if2.in_valid = 1'b0;
    repeat (3) step();

    check("final_q2_empty", q2.size(), 32'd0);
    check("final_q3_empty", q3.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
